branch_resolve_unit: RTL

- Parametrised next-generation branch evaluation block for the ID/EX boundary.
- Evaluates the six conditional-branch conditions on XLEN-wide operands and computes the actual next PC (target or fall-through).
- Registers the result in one valid/ready output stage and flags mispredictions against the fetch-time prediction.
- Owns a DEPTH-entry 2-bit saturating branch history table (BHT): combinational lookup for fetch, trained when a resolved branch leaves the block.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_cmp.sv | 28 ++
 rtl/branch_resolve_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared branch condition codes, 2-bit counter type and its saturating update.
//   BEQ..BGEU : funct3 encodings of the six conditional branches
//   ctr_t     : 2-bit saturating counter, SNT/WNT/WT/ST states
//   ctr_next  : counter step toward the resolved outcome, saturating at both ends
package branch_pkg;
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;
    typedef logic [1:0] ctr_t;
    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;
    function automatic ctr_t ctr_next(input ctr_t c, input logic t);
        return t ? ((c == ST) ? ST : c + 2'b01) : ((c == SNT) ? SNT : c - 2'b01);
    endfunction
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational evaluator of the conditional-branch condition.
//   sb_type      : instruction is a conditional branch
//   funct3       : condition code
//   rs1, rs2     : XLEN-wide operands
//   taken        : condition holds (0 for non-branches and reserved codes)
//   illegal      : branch with reserved funct3 (010/011)
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            sb_type,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);
    logic base;
    // funct3[2:1] selects EQ / LT / LTU, funct3[0] inverts into NE / GE / GEU
    always_comb begin
        base    = (funct3[2:1] == BLTU[2:1]) ? (rs1 < rs2)
                : (funct3[2:1] == BLT[2:1])  ? ($signed(rs1) < $signed(rs2))
                : (rs1 == rs2);
        illegal = sb_type & (funct3[2:1] == 2'b01);
        taken   = sb_type & ~illegal & (base ^ funct3[0]);
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves conditional branches into a registered valid/ready
// result stage, flags mispredictions and trains a 2-bit branch history table.
//   clk, rst_n               : clock, asynchronous active-low reset
//   flush                    : kills the held result and blocks acceptance this cycle
//   in_valid / in_ready      : input handshake
//   sb_type, funct3          : branch flag and condition code
//   rs1_data, rs2_data       : operands
//   pc, imm, pred_taken      : branch PC, offset, fetch-time prediction
//   out_valid / out_ready    : output handshake
//   taken, next_pc           : resolved outcome and next PC
//   mispredict, illegal      : prediction miss, reserved condition code
//   lookup_pc / lookup_taken : combinational BHT lookup for fetch
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int   XLEN      = 32,
    parameter int   BHT_DEPTH = 64,
    parameter ctr_t BHT_INIT  = WNT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            sb_type,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] next_pc,
    output logic            mispredict,
    output logic            illegal,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken
);
    localparam int IW = $clog2(BHT_DEPTH);
    ctr_t          bht [BHT_DEPTH];
    logic [IW-1:0] held_idx;
    logic          held_sb;
    logic          cmp_taken;
    logic          cmp_illegal;
    logic          accept;
    logic          train;
    logic          unused_bits;
    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .sb_type (sb_type),
        .funct3  (funct3),
        .rs1     (rs1_data),
        .rs2     (rs2_data),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );
    assign in_ready     = ~flush & (~out_valid | out_ready);
    assign accept       = in_valid & in_ready;
    assign train        = out_valid & out_ready & held_sb & ~illegal & ~flush;
    // reads the array before this edge's write lands, so lookup sees the pre-update counter
    assign lookup_taken = bht[lookup_pc[IW+1:2]][1];
    assign unused_bits  = ^{lookup_pc[XLEN-1:IW+2], lookup_pc[1:0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            taken      <= 1'b0;
            next_pc    <= '0;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
            held_sb    <= 1'b0;
            held_idx   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            taken      <= cmp_taken;
            next_pc    <= pc + (cmp_taken ? imm : XLEN'(4));
            mispredict <= sb_type & ~cmp_illegal & (cmp_taken ^ pred_taken);
            illegal    <= cmp_illegal;
            held_sb    <= sb_type;
            held_idx   <= pc[IW+1:2];
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_INIT;
        end else if (train) begin
            bht[held_idx] <= ctr_next(bht[held_idx], taken);
        end
    end
endmodule
